// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: multi-cycle unsigned shift-and-add multiplier using a carry-lookahead adder.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b operand handshake;
// out_valid/out_ready/product result handshake; busy high while RUN or DONE.
// Optional MULT_EARLY_EXIT_EN finishes early once the remaining multiplier bits are all zero.

module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             acc;
    assign g = a & b;
    assign p = a ^ b;
    // Each carry is derived from g/p/cin alone, never from a neighbouring carry.
    always_comb begin
        c = '0;
        acc = 1'b0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            acc = cin;
            for (int j = 0; j <= i; j++)
                acc = g[j] | (p[j] & acc);
            c[i+1] = acc;
        end
    end
    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   p_reg, p_nxt;
    logic [WIDTH-1:0]     a_reg, a_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
`ifdef MULT_EARLY_EXIT_EN
    localparam logic [WIDTH-1:0] ONES = '1;
`endif
    carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
        .a    (p_reg[2*WIDTH-1:WIDTH]),
        .b    (a_reg),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            p_reg <= '0;
            a_reg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            p_reg <= p_nxt;
            a_reg <= a_nxt;
            cnt   <= cnt_nxt;
        end
    always_comb begin
        state_nxt = state;
        p_nxt = p_reg;
        a_nxt = a_reg;
        cnt_nxt = cnt;
        case (state)
            IDLE: if (in_valid) begin
                a_nxt = a;
                p_nxt = {{WIDTH{1'b0}}, b};
                cnt_nxt = '0;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_nxt = cnt + 1'b1;
                // The adder carry lands in the MSB, so the product never overflows.
                p_nxt = p_reg[0] ? {cout, sum, p_reg[WIDTH-1:1]} : p_reg >> 1;
                state_nxt = (cnt == LAST) ? DONE : RUN;
`ifdef MULT_EARLY_EXIT_EN
                // Low WIDTH-cnt bits of P are the unconsumed multiplier bits.
                if ((p_reg[WIDTH-1:0] & (ONES >> cnt)) == '0) begin
                    p_nxt = p_reg >> (CW'(WIDTH) - cnt);
                    state_nxt = DONE;
                end
`endif
            end
            DONE: state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = p_reg;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scoreboard bench for shift_add_multiplier with a plain-arithmetic reference.
module tb_shift_add_multiplier;
    localparam int W = 8;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] a = 0, b = 0;
    logic in_ready, out_valid, busy;
    logic [2*W-1:0] product;
    typedef struct { longint prod; int lat; int acc; } exp_t;
    exp_t exp_q[$];
    int cyc = 0, pass = 0, total = 0, excl_err = 0, n_push = 0, n_pop = 0, ready_mode = 1;
    bit seen = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Cycles from accept edge to out_valid, from the multiplier value alone.
    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef MULT_EARLY_EXIT_EN
        int hb;
        hb = -1;
        for (int i = 0; i < W; i++) if (bv[i]) hb = i;
        if (hb < 0) return 1;
        return (hb + 2 < W) ? hb + 2 : W;
`else
        return W;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) seen = 0;
        else begin
            if (in_ready && out_valid) excl_err++;
            if (in_ready == busy) excl_err++;
            if (out_valid && !seen) begin
                seen = 1;
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
            end
            if (out_valid && out_ready) begin
                seen = 0;
                if (exp_q.size() == 0) chk("unexpected_product", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("product", product, e.prod);
                    n_pop++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (ready_mode == 2) ? 1'($urandom % 2) : (ready_mode == 1);
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
        bit ok;
        exp_t e;
        ok = 0;
        @(posedge clk);
        #1;
        in_valid = 1; a = av; b = bv;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else begin
            e.prod = longint'(av) * longint'(bv);
            e.lat = exp_lat(bv);
            e.acc = cyc + 1;
            exp_q.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
        in_valid = 0; a = W'($urandom); b = W'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_product"}, product, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ir_hi;
        bit got;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;
        send(13, 11);
        ir_hi = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (in_ready) ir_hi++;
        end
        chk("in_ready_low_in_run", ir_hi, 0);
        wait_idle();
        send(255, 255); wait_idle();
        send(200, 0); wait_idle();
        send(0, 200); wait_idle();
        ready_mode = 0;
        send(7, 9);
        @(posedge clk); #1;
        in_valid = 1; a = 3; b = 3;
        @(posedge clk); #1;
        in_valid = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin got = 1; break; end
        end
        chk("stall_reached_done", got, 1);
        @(posedge clk); #1;
        in_valid = 1; a = 3; b = 3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_product", product, 63);
            chk("stall_valid", out_valid, 1);
            @(posedge clk); #1;
            in_valid = 0;
        end
        ready_mode = 1;
        wait_idle();
        send(3, 3); wait_idle();
        send(100, 100);
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1 check_reset_outputs("abort");
        n_push -= exp_q.size();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        repeat (12) @(negedge clk);
        send(2, 5); wait_idle();
        ready_mode = 2;
        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom % 4 == 0) ? W'($urandom % 16) : W'($urandom);
            send(ra, rb);
            repeat ($urandom % 3) @(posedge clk);
        end
        wait_idle();
        chk("handshake_exclusive", excl_err, 0);
        chk("transaction_count", n_pop, n_push);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
